// File: rtl/pcie_msi_irq.sv
// MSI interrupt generator for PCIe PF0: latches per-vector requests into a pending
// register, round-robin picks one vector at a time and retries failed or timed-out issues.
module pcie_msi_irq #(
  parameter int MSI_COUNT   = 32,
  parameter int RETRY_DELAY = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MSI_COUNT-1:0] msi_irq,
  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [31:0]          cfg_interrupt_msi_int,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic                 cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
  output logic [3:0]           cfg_interrupt_msi_select,
  output logic [3:0]           cfg_interrupt_msi_function_number,
  output logic [2:0]           cfg_interrupt_msi_attr,
  output logic                 cfg_interrupt_msi_tph_present,
  output logic [1:0]           cfg_interrupt_msi_tph_type,
  output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
  output logic                 irq_timeout,
  output logic [1:0]           fsm_state
);

  localparam int IW   = (MSI_COUNT > 1) ? $clog2(MSI_COUNT) : 1;
  localparam int CMAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [IW-1:0] IDX_MASK = IW'(MSI_COUNT - 1);

  // fsm_state encoding: 0 IDLE, 1 ISSUE, 2 WAIT, 3 BACKOFF
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_BACKOFF = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [MSI_COUNT-1:0] pending_q, pending_d, req_vec;
  logic [IW-1:0]        cur_q, cur_d, last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 en_q, strobe_q;
  logic [2:0]           alloc_n;
  logic [31:0]          mask32;
  logic [IW-1:0]        alias_mask;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx, scan_idx;
  logic                 issue, requeue, timeout_hit;

  // Allocated vector count is 2^n with n clamped to 5; requests alias onto it.
  always_comb begin
    alloc_n    = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
    mask32     = (32'd1 << alloc_n) - 32'd1;
    alias_mask = mask32[IW-1:0] & IDX_MASK;
  end

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < MSI_COUNT; i++) begin
      if (msi_irq[i]) req_vec[IW'(i) & alias_mask] = 1'b1;
    end
  end

  // Round-robin search starting just after the last issued vector.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_q;
    scan_idx   = '0;
    for (int off = 1; off <= MSI_COUNT; off++) begin
      scan_idx = (last_q + IW'(off)) & IDX_MASK;
      if (!pick_valid && pending_q[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    issue       = 1'b0;
    requeue     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q && pick_valid) begin
          cur_d   = pick_idx;
          last_d  = pick_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue   = 1'b1;
        cnt_d   = CW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cfg_interrupt_msi_fail) begin
          requeue = 1'b1;
          cnt_d   = CW'(1);
          state_d = S_BACKOFF;
        end else if (cfg_interrupt_msi_sent) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          requeue     = 1'b1;
          cnt_d       = CW'(1);
          state_d     = S_BACKOFF;
        end else if (cnt_q != CW'(CMAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BACKOFF: begin
        if (cnt_q >= CW'(RETRY_DELAY)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // New requests are OR-ed last so they win over a same-cycle issue clear.
  always_comb begin
    pending_d = pending_q;
    if (issue)   pending_d[cur_q] = 1'b0;
    if (requeue) pending_d[cur_q] = 1'b1;
    pending_d = pending_d | req_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      cur_q     <= '0;
      last_q    <= IW'(MSI_COUNT - 1);
      cnt_q     <= '0;
      en_q      <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      en_q      <= cfg_interrupt_msi_enable[0];
      strobe_q  <= (pending_d != pending_q);
    end
  end

  always_comb begin
    cfg_interrupt_msi_int = '0;
    if (state_q == S_ISSUE) cfg_interrupt_msi_int = 32'd1 << cur_q;
  end

  assign cfg_interrupt_msi_pending_status             = 32'(pending_q);
  assign cfg_interrupt_msi_pending_status_data_enable = strobe_q;
  assign cfg_interrupt_msi_pending_status_function_num = '0;
  assign cfg_interrupt_msi_select                     = '0;
  assign cfg_interrupt_msi_function_number            = '0;
  assign cfg_interrupt_msi_attr                       = '0;
  assign cfg_interrupt_msi_tph_present                = 1'b0;
  assign cfg_interrupt_msi_tph_type                   = '0;
  assign cfg_interrupt_msi_tph_st_tag                 = '0;
  assign irq_timeout                                  = timeout_hit;
  assign fsm_state                                    = state_q;

endmodule

// File: tb/tb_pcie_msi_irq.sv
// Directed self-checking bench for pcie_msi_irq: latency, round-robin order, retry,
// aliasing, enable gating, timeout and asynchronous reset.
module tb_pcie_msi_irq;

  logic        clk;
  logic        rst_n;
  logic [31:0] msi_irq;
  logic [3:0]  msi_enable;
  logic [11:0] msi_mmenable;
  logic        msi_sent;
  logic        msi_fail;
  logic [31:0] msi_int;
  logic [31:0] pend_status;
  logic        pend_de;
  logic [3:0]  pend_fn, msi_select, msi_fn;
  logic [2:0]  msi_attr;
  logic        tph_present;
  logic [1:0]  tph_type;
  logic [8:0]  tph_st_tag;
  logic        irq_timeout;
  logic [1:0]  fsm_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_BACKOFF = 2'd3;

  pcie_msi_irq #(.MSI_COUNT(32), .RETRY_DELAY(16), .TIMEOUT(1024)) dut (
    .clk                                          (clk),
    .rst_n                                        (rst_n),
    .msi_irq                                      (msi_irq),
    .cfg_interrupt_msi_enable                     (msi_enable),
    .cfg_interrupt_msi_mmenable                   (msi_mmenable),
    .cfg_interrupt_msi_sent                       (msi_sent),
    .cfg_interrupt_msi_fail                       (msi_fail),
    .cfg_interrupt_msi_int                        (msi_int),
    .cfg_interrupt_msi_pending_status             (pend_status),
    .cfg_interrupt_msi_pending_status_data_enable (pend_de),
    .cfg_interrupt_msi_pending_status_function_num(pend_fn),
    .cfg_interrupt_msi_select                     (msi_select),
    .cfg_interrupt_msi_function_number            (msi_fn),
    .cfg_interrupt_msi_attr                       (msi_attr),
    .cfg_interrupt_msi_tph_present                (tph_present),
    .cfg_interrupt_msi_tph_type                   (tph_type),
    .cfg_interrupt_msi_tph_st_tag                 (tph_st_tag),
    .irq_timeout                                  (irq_timeout),
    .fsm_state                                    (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; observation point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [11:0] mm);
    rst_n        = 1'b0;
    msi_irq      = '0;
    msi_sent     = 1'b0;
    msi_fail     = 1'b0;
    msi_enable   = en;
    msi_mmenable = mm;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait up to budget cycles for a nonzero msi_int; n = cycles taken, -1 on expiry.
  task automatic wait_int(input int budget, output logic [31:0] v, output int n);
    bit found;
    found = 1'b0;
    v     = '0;
    n     = -1;
    for (int c = 1; c <= budget && !found; c++) begin
      tick();
      if (msi_int != 32'd0) begin
        found = 1'b1;
        v     = msi_int;
        n     = c;
      end
    end
  endtask

  task automatic answer_sent();
    tick();
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(4'h1, 12'h005);
    total_cnt++; if (msi_int !== 32'd0) $display("FAIL reset_int: got %h expected 0", msi_int); else pass_cnt++;
    total_cnt++; if (pend_status !== 32'd0) $display("FAIL reset_pend: got %h expected 0", pend_status); else pass_cnt++;
    total_cnt++; if (pend_de !== 1'b0) $display("FAIL reset_de: got %b expected 0", pend_de); else pass_cnt++;
    total_cnt++; if (irq_timeout !== 1'b0) $display("FAIL reset_tmo: got %b expected 0", irq_timeout); else pass_cnt++;
    total_cnt++; if (fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected 0", fsm_state); else pass_cnt++;
    total_cnt++;
    if ({pend_fn, msi_select, msi_fn, msi_attr, tph_present, tph_type, tph_st_tag} !== 27'd0)
      $display("FAIL reset_consts: got nonzero expected 0");
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset(4'h1, 12'h005);
    msi_irq = 32'h0000_0020;              // cycle 0
    tick();                               // cycle 1
    msi_irq = '0;
    total_cnt++; if (pend_status !== 32'h20) $display("FAIL single_pend_c1: got %h expected 00000020", pend_status); else pass_cnt++;
    total_cnt++; if (pend_de !== 1'b1) $display("FAIL single_de_c1: got %b expected 1", pend_de); else pass_cnt++;
    total_cnt++; if (msi_int !== 32'd0) $display("FAIL single_int_c1: got %h expected 0", msi_int); else pass_cnt++;
    tick();                               // cycle 2
    total_cnt++; if (msi_int !== 32'h20) $display("FAIL single_int_c2: got %h expected 00000020", msi_int); else pass_cnt++;
    tick();                               // cycle 3
    total_cnt++; if (msi_int !== 32'd0) $display("FAIL single_int_c3: got %h expected 0", msi_int); else pass_cnt++;
    total_cnt++; if (pend_status !== 32'd0) $display("FAIL single_pend_c3: got %h expected 0", pend_status); else pass_cnt++;
    total_cnt++; if (fsm_state !== ST_WAIT) $display("FAIL single_wait: got %0d expected 2", fsm_state); else pass_cnt++;
    tick();
    tick();                               // cycle 5
    msi_sent = 1'b1;
    tick();                               // cycle 6
    msi_sent = 1'b0;
    total_cnt++; if (fsm_state !== ST_IDLE) $display("FAIL single_idle: got %0d expected 0", fsm_state); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_order [3];
    logic [31:0] v;
    int          n;
    exp_order[0] = 32'h01;
    exp_order[1] = 32'h08;
    exp_order[2] = 32'h80;
    do_reset(4'h1, 12'h005);
    msi_irq = 32'h0000_0089;
    tick();
    msi_irq = '0;
    for (int k = 0; k < 3; k++) begin
      wait_int(20, v, n);
      total_cnt++;
      if (v !== exp_order[k]) $display("FAIL rr_order%0d: got %h expected %h", k, v, exp_order[k]);
      else pass_cnt++;
      answer_sent();
    end
  endtask

  task automatic test_fail_retry();
    logic [31:0] v;
    int          n;
    do_reset(4'h1, 12'h005);
    msi_irq = 32'h04;                     // cycle 0
    tick();
    msi_irq = '0;
    tick();                               // cycle 2: issue
    tick();                               // cycle 3: WAIT
    msi_fail = 1'b1;
    tick();                               // cycle 4
    msi_fail = 1'b0;
    total_cnt++; if (fsm_state !== ST_BACKOFF) $display("FAIL fail_backoff: got %0d expected 3", fsm_state); else pass_cnt++;
    total_cnt++; if (pend_status !== 32'h04) $display("FAIL fail_requeue: got %h expected 00000004", pend_status); else pass_cnt++;
    wait_int(40, v, n);                   // retry expected in cycle 3+16+2 = 21
    total_cnt++; if (n !== 17) $display("FAIL fail_retry_time: got %0d expected 17", n); else pass_cnt++;
    total_cnt++; if (v !== 32'h04) $display("FAIL fail_retry_vec: got %h expected 00000004", v); else pass_cnt++;
    answer_sent();
    tick();
    total_cnt++; if (pend_status !== 32'd0) $display("FAIL fail_pend_clear: got %h expected 0", pend_status); else pass_cnt++;
    total_cnt++; if (fsm_state !== ST_IDLE) $display("FAIL fail_final_idle: got %0d expected 0", fsm_state); else pass_cnt++;
  endtask

  task automatic test_alias();
    logic [31:0] v;
    int          n;
    do_reset(4'h1, 12'h002);
    msi_irq = 32'h0000_2000;
    tick();
    msi_irq = '0;
    total_cnt++; if (pend_status !== 32'h02) $display("FAIL alias_pend: got %h expected 00000002", pend_status); else pass_cnt++;
    wait_int(5, v, n);
    total_cnt++; if (v !== 32'h02 || n !== 1) $display("FAIL alias_int: got %h at %0d expected 00000002 at 1", v, n); else pass_cnt++;
    tick();                               // WAIT: sent and fail together, fail wins
    msi_sent = 1'b1;
    msi_fail = 1'b1;
    tick();
    msi_sent = 1'b0;
    msi_fail = 1'b0;
    total_cnt++; if (fsm_state !== ST_BACKOFF) $display("FAIL alias_fail_wins: got %0d expected 3", fsm_state); else pass_cnt++;
  endtask

  task automatic test_disable();
    logic [31:0] v;
    int          n;
    int          seen;
    do_reset(4'h0, 12'h005);
    msi_irq = 32'h10;
    tick();
    msi_irq = '0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (msi_int != 32'd0) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL dis_no_int: got %0d issues expected 0", seen); else pass_cnt++;
    total_cnt++; if (pend_status !== 32'h10) $display("FAIL dis_pend_kept: got %h expected 00000010", pend_status); else pass_cnt++;
    msi_enable = 4'h1;
    wait_int(10, v, n);
    total_cnt++; if (v !== 32'h10 || n !== 2) $display("FAIL dis_reenable: got %h at %0d expected 00000010 at 2", v, n); else pass_cnt++;
  endtask

  task automatic test_timeout_reset();
    logic [31:0] v;
    int          n;
    int          seen;
    bit          hit;
    do_reset(4'h1, 12'h005);
    msi_irq = 32'h02;
    tick();
    msi_irq = '0;
    tick();                               // cycle 2: issue
    hit = 1'b0;
    n   = -1;
    for (int c = 1; c <= 1100 && !hit; c++) begin
      tick();
      if (irq_timeout) begin
        hit = 1'b1;
        n   = c;
      end
    end
    total_cnt++; if (n !== 1024) $display("FAIL tmo_time: got %0d expected 1024", n); else pass_cnt++;
    tick();
    total_cnt++; if (irq_timeout !== 1'b0) $display("FAIL tmo_pulse_len: got %b expected 0", irq_timeout); else pass_cnt++;
    total_cnt++; if (pend_status !== 32'h02) $display("FAIL tmo_requeue: got %h expected 00000002", pend_status); else pass_cnt++;
    wait_int(30, v, n);                   // 17 more cycles after the one already taken
    total_cnt++; if (v !== 32'h02 || n !== 17) $display("FAIL tmo_retry: got %h at %0d expected 00000002 at 17", v, n); else pass_cnt++;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (fsm_state !== ST_IDLE) $display("FAIL rst_state: got %0d expected 0", fsm_state); else pass_cnt++;
    total_cnt++; if (pend_status !== 32'd0 || msi_int !== 32'd0 || pend_de !== 1'b0)
      $display("FAIL rst_outputs: got pend %h int %h de %b expected all 0", pend_status, msi_int, pend_de);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (msi_int != 32'd0) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL rst_no_retry: got %0d issues expected 0", seen); else pass_cnt++;
  endtask

  initial begin
    rst_n        = 1'b0;
    msi_irq      = '0;
    msi_enable   = '0;
    msi_mmenable = '0;
    msi_sent     = 1'b0;
    msi_fail     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fail_retry();
    test_alias();
    test_disable();
    test_timeout_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pcie_msi_irq.md
# pcie_msi_irq

MSI interrupt generator between the core's interrupt sources and the PCIe hard block's MSI configuration interface on physical function 0. It latches per-vector request pulses into a pending register and picks one pending vector at a time by round-robin arbitration. Each pick is issued as a one-cycle one-hot pulse on `cfg_interrupt_msi_int`. The block then waits for `cfg_interrupt_msi_sent` or `cfg_interrupt_msi_fail`, and retries a failed vector after a backoff.

## Interface
Parameters:
- `MSI_COUNT`, 32: number of request inputs and vectors; power of two, 1 to 32.
- `RETRY_DELAY`, 16: cycles spent in BACKOFF after a fail or timeout, ≥1.
- `TIMEOUT`, 1024: WAIT-state cycles before an issue is abandoned, ≥2.

Ports:
- `clk`, in, 1: PCIe user clock, 250 MHz.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `msi_irq`, in, MSI_COUNT: per-vector request pulses; a bit held high requests every cycle, and repeats coalesce.
- `cfg_interrupt_msi_enable`, in, 4: only bit 0 (PF0) is used.
- `cfg_interrupt_msi_mmenable`, in, 12: bits [2:0] give the allocated vector count, 2^n, with n clamped to 5.
- `cfg_interrupt_msi_sent`, in, 1: one-cycle success indication from the hard block.
- `cfg_interrupt_msi_fail`, in, 1: one-cycle failure indication from the hard block.
- `cfg_interrupt_msi_int`, out, 32: one-hot issue pulse.
- `cfg_interrupt_msi_pending_status`, out, 32: mirror of the pending register; bits ≥ MSI_COUNT are 0.
- `cfg_interrupt_msi_pending_status_data_enable`, out, 1: one-cycle load strobe for the pending status.
- `cfg_interrupt_msi_pending_status_function_num`, `cfg_interrupt_msi_select`, `cfg_interrupt_msi_function_number`, out, 4 each: constant 0.
- `cfg_interrupt_msi_attr`, out, 3; `cfg_interrupt_msi_tph_present`, out, 1; `cfg_interrupt_msi_tph_type`, out, 2; `cfg_interrupt_msi_tph_st_tag`, out, 9: all constant 0.
- `irq_timeout`, out, 1: one-cycle pulse when an issue times out.

## Operation
- Vector aliasing: a request on bit i sets pending bit (i & (2^n − 1)). n is sampled every cycle.
- Pending register update, in order of precedence:
  - cleared at the issue of its vector;
  - re-set on fail or timeout of its vector;
  - a new request always wins over a same-cycle clear.
- Requests arriving while a vector is in flight are kept, so no request is lost.
- Pending bits are kept while `msi_enable[0]`=0. They are issued after re-enable.
- Round-robin arbitration: the search starts at (last issued index + 1) mod MSI_COUNT. The last index resets to MSI_COUNT−1, so vector 0 wins first.
- FSM states and transitions:
  - IDLE: if `enable[0]` and pending≠0, pick a vector and go to ISSUE.
  - ISSUE: `msi_int` = one-hot of the chosen vector for exactly one cycle; clear that pending bit; go to WAIT.
  - WAIT: on `sent`, go to IDLE.
  - WAIT: on `fail`, re-set the pending bit and go to BACKOFF.
  - WAIT: if the counter reaches TIMEOUT, pulse `irq_timeout`, re-set the pending bit and go to BACKOFF.
  - BACKOFF: count RETRY_DELAY cycles, then go to IDLE.
- `sent` or `fail` outside WAIT is ignored.
- If `sent` and `fail` arrive in the same cycle, `fail` wins.
- Disabling in WAIT or BACKOFF does not abort; the FSM stalls only in IDLE.
- `pending_status_data_enable` pulses in the cycle after any change of the pending register, with `pending_status` already updated.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE. Pending, the counters and the data-enable strobe are 0.
- Latency from an idle, empty state:
  - request in cycle 0;
  - pending bit and status visible in cycle 1, data_enable high in cycle 1;
  - `msi_int` high in cycle 2 only.
- `sent` arriving in cycle k returns the FSM to IDLE in cycle k+1. The next `msi_int` is at k+2 at the earliest.
- `fail` in cycle k: BACKOFF runs cycles k+1 … k+RETRY_DELAY, IDLE at k+RETRY_DELAY+1, retry pulse at k+RETRY_DELAY+2.
- Timeout: `irq_timeout` is high in the cycle the WAIT counter reaches TIMEOUT, i.e. TIMEOUT cycles after the `msi_int` cycle.
- Counters saturate and never wrap.
- Asserting `rst_n` mid-operation immediately clears pending and returns to IDLE. No outstanding sent/fail is awaited after reset.

## Test plan
- Pulse `msi_irq[5]` at cycle 0 with enable=1 and mmenable n=5: `msi_int`=0x20 in cycle 2, `pending_status` = 0x20 in cycle 1 then 0 after the issue. Send `sent` 3 cycles later: FSM returns to IDLE.
- Pulse bits 0, 3 and 7 in one cycle, answering every issue with `sent`: issue order 0x01, 0x08, 0x80.
- Request vector 2 and answer with `fail`: after RETRY_DELAY=16 cycles, `msi_int`=0x04 again. Answer with `sent`: pending becomes 0.
- Set n=2 (4 vectors) and request bit 13: pending bit 1 is set and `msi_int`=0x02.
- Hold enable=0, request bit 4, then enable 50 cycles later: no `msi_int` while disabled, 0x10 issued 2 cycles after enable.
- Give no sent/fail after an issue: `irq_timeout` pulses at TIMEOUT=1024 and the vector retries. Deassert `rst_n` mid-WAIT: all outputs return to 0 the same cycle and no retry follows.
